// File: rtl/stall_ctrl_pkg.sv
// Shared constants for the stall controller and the ALU-side mult/div unit.
// Both sides take their cycle counts from here, so the front-end timing
// model cannot drift away from the real HI/LO datapath.
package stall_ctrl_pkg;

    // MdType encoding driven by the E-stage decoder.
    typedef enum logic {
        MD_MULT = 1'b0,
        MD_DIV  = 1'b1
    } md_type_e;

    // Default latencies. The HI/LO unit must use the same values.
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Occupancy states of the HI/LO unit timing model.
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // Individual reasons for a front-end stall, kept apart for readability.
    typedef struct packed {
        logic load_use;   // load-use hazard from the hazard unit
        logic md_hazard;  // D-stage HI/LO user while the unit is occupied
    } stall_cause_t;

    // Busy latency of one operation of the given type.
    function automatic int md_latency(md_type_e md_type, int mult_n, int div_n);
        return (md_type == MD_DIV) ? div_n : mult_n;
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Busy tracker for the HI/LO unit. A start in IDLE loads the operation's
// latency and the counter runs down to zero; MdBusy is high while it is
// non-zero. A start that arrives while busy is dropped and latched as an error.
module md_busy_cnt
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic MdStart,
    input  logic MdType,
    output logic MdBusy,
    output logic MdErr
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] load_val;

    // Latency selected by the type of the operation being issued.
    assign load_val = CNT_W'(md_latency(md_type_e'(MdType), MULT_CYCLES, DIV_CYCLES));

    // Occupancy FSM: load on an accepted start, count down to zero, flag overlaps.
    // NOTE: state is written only with non-blocking assignments so every
    // register in this block samples the pre-edge values of the others.
    always_ff @(posedge Clk) begin
        // NOTE: the reset is synchronous and clears every register here; there
        // is no storage array that could be left out of the reset.
        if (Reset) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            MdBusy <= 1'b0;
            MdErr  <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (MdStart && (load_val != '0)) begin
                        state  <= MD_BUSY;
                        cnt    <= load_val;
                        MdBusy <= 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (MdStart) begin
                        MdErr <= 1'b1;
                    end
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state  <= MD_IDLE;
                        MdBusy <= 1'b0;
                    end
                end
                default: begin
                    state  <= MD_IDLE;
                    cnt    <= '0;
                    MdBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/stall_ctrl.sv
// Front-end stall and flush controller. Merges the load-use request with the
// HI/LO occupancy model, drives the PC / F-D enables and the D-E bubble, and
// counts stalled cycles for performance reporting.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MdStart,
    input  logic        MdType,
    input  logic        D_UseMd,
    input  logic        LoadUseHaz,
    output logic        PC_En,
    output logic        D_En,
    output logic        E_Clr,
    output logic        MdBusy,
    output logic        MdErr,
    output logic [31:0] StallCnt
);

    stall_cause_t cause;
    logic         stall;

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_cnt (
        .Clk     (Clk),
        .Reset   (Reset),
        .MdStart (MdStart),
        .MdType  (MdType),
        .MdBusy  (MdBusy),
        .MdErr   (MdErr)
    );

    // A HI/LO user stalls both while the unit is busy and in the issue cycle itself.
    always_comb begin
        cause.load_use  = LoadUseHaz;
        cause.md_hazard = D_UseMd & (MdBusy | MdStart);
        stall           = |cause;
    end

    // Pipeline controls; during Reset everything is enabled and flushed.
    // NOTE: each output gets its value before any branch, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        PC_En = 1'b1;
        D_En  = 1'b1;
        E_Clr = 1'b1;
        if (!Reset) begin
            PC_En = ~stall;
            D_En  = ~stall;
            E_Clr = stall;
        end
    end

    // Stall-cycle counter; simultaneous causes count once, and it wraps freely.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            StallCnt <= '0;
        end else if (stall) begin
            StallCnt <= StallCnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a cycle-index reference model.
module tb_stall_ctrl;

    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MdStart;
    logic        MdType;
    logic        D_UseMd;
    logic        LoadUseHaz;
    logic        PC_En;
    logic        D_En;
    logic        E_Clr;
    logic        MdBusy;
    logic        MdErr;
    logic [31:0] StallCnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    stall_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .MdStart    (MdStart),
        .MdType     (MdType),
        .D_UseMd    (D_UseMd),
        .LoadUseHaz (LoadUseHaz),
        .PC_En      (PC_En),
        .D_En       (D_En),
        .E_Clr      (E_Clr),
        .MdBusy     (MdBusy),
        .MdErr      (MdErr),
        .StallCnt   (StallCnt)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles are numbered since the last reset; an accepted
    // start in cycle s makes the unit busy in cycles s+1 .. s+n.
    int          m_t      = 0;
    int          m_start  = 0;
    int          m_n      = 0;
    bit          m_active = 1'b0;
    bit          m_err    = 1'b0;
    logic [31:0] m_cnt    = '0;

    function automatic bit m_busy();
        return m_active && (m_t > m_start) && (m_t <= m_start + m_n);
    endfunction

    always @(posedge Clk) begin
        bit b;
        bit s;
        if (Reset) begin
            m_t      = 0;
            m_active = 1'b0;
            m_err    = 1'b0;
            m_cnt    = '0;
        end else begin
            b = m_busy();
            s = LoadUseHaz | (D_UseMd & (b | MdStart));
            if (s) m_cnt = m_cnt + 32'd1;
            if (MdStart) begin
                if (b) begin
                    m_err = 1'b1;
                end else begin
                    m_active = 1'b1;
                    m_start  = m_t;
                    m_n      = MdType ? N_DIV : N_MULT;
                end
            end
            m_t++;
        end
    end

    // Compare process: every cycle, sampled at the falling edge.
    always @(negedge Clk) begin
        bit eb;
        bit es;
        if (chk_en) begin
            eb = m_busy();
            es = LoadUseHaz | (D_UseMd & (eb | MdStart));
            check("cmp_pc_en",  {31'd0, PC_En},  {31'd0, Reset ? 1'b1 : ~es});
            check("cmp_d_en",   {31'd0, D_En},   {31'd0, Reset ? 1'b1 : ~es});
            check("cmp_e_clr",  {31'd0, E_Clr},  {31'd0, Reset ? 1'b1 : es});
            check("cmp_busy",   {31'd0, MdBusy}, {31'd0, eb});
            check("cmp_err",    {31'd0, MdErr},  {31'd0, m_err});
            check("cmp_stlcnt", StallCnt,        m_cnt);
        end
    end

    int busy_seen;
    int stall_seen;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick_count();
        @(negedge Clk);
        busy_seen  += int'(MdBusy);
        stall_seen += int'(!PC_En);
        @(posedge Clk);
        #1;
    endtask

    task automatic clr_counts();
        busy_seen  = 0;
        stall_seen = 0;
    endtask

    task automatic idle_inputs();
        MdStart    = 1'b0;
        MdType     = 1'b0;
        D_UseMd    = 1'b0;
        LoadUseHaz = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        idle_inputs();
        tick();
        chk_en = 1'b1;
        tick();
        Reset = 1'b0;

        // Reset state with idle inputs.
        @(negedge Clk);
        check("rst_pc_en",  {31'd0, PC_En},  32'd1);
        check("rst_d_en",   {31'd0, D_En},   32'd1);
        check("rst_e_clr",  {31'd0, E_Clr},  32'd0);
        check("rst_busy",   {31'd0, MdBusy}, 32'd0);
        check("rst_err",    {31'd0, MdErr},  32'd0);
        check("rst_stlcnt", StallCnt,        32'd0);
        tick();

        // Multiply with a HI/LO user held in D: 5 busy, 6 stalled.
        clr_counts();
        MdStart = 1'b1; MdType = 1'b0; D_UseMd = 1'b1;
        tick_count();
        MdStart = 1'b0;
        repeat (8) tick_count();
        check("mul_busy_cycles",  busy_seen,  32'd5);
        check("mul_stall_cycles", stall_seen, 32'd6);
        check("mul_stlcnt",       StallCnt,   32'd6);
        D_UseMd = 1'b0;

        // Divide with no HI/LO user: 10 busy, no stalls.
        clr_counts();
        MdStart = 1'b1; MdType = 1'b1;
        tick_count();
        MdStart = 1'b0;
        repeat (12) tick_count();
        check("div_busy_cycles",  busy_seen,  32'd10);
        check("div_stall_cycles", stall_seen, 32'd0);
        check("div_stlcnt",       StallCnt,   32'd6);

        // Load-use pulse inside a multiply stall window: no double count.
        clr_counts();
        MdStart = 1'b1; MdType = 1'b0; D_UseMd = 1'b1;
        tick_count();
        MdStart = 1'b0;
        tick_count();
        LoadUseHaz = 1'b1;
        tick_count();
        LoadUseHaz = 1'b0;
        repeat (6) tick_count();
        check("lu_busy_cycles",  busy_seen,  32'd5);
        check("lu_stall_cycles", stall_seen, 32'd6);
        check("lu_stlcnt",       StallCnt,   32'd12);
        D_UseMd = 1'b0;

        // Second start at busy cycle 3: ignored, error latched and sticky.
        clr_counts();
        MdStart = 1'b1; MdType = 1'b0;
        tick_count();
        MdStart = 1'b0;
        repeat (2) tick_count();
        MdStart = 1'b1; MdType = 1'b1;
        tick_count();
        MdStart = 1'b0;
        repeat (6) tick_count();
        check("err_busy_cycles", busy_seen,         32'd5);
        check("err_flag",        {31'd0, MdErr},    32'd1);
        repeat (4) tick();
        check("err_sticky",      {31'd0, MdErr},    32'd1);
        check("err_stlcnt",      StallCnt,          32'd12);

        // Reset at busy cycle 4 of a divide, with stall requests present.
        MdStart = 1'b1; MdType = 1'b1;
        tick();
        MdStart = 1'b0;
        repeat (3) tick();
        Reset = 1'b1; D_UseMd = 1'b1; LoadUseHaz = 1'b1;
        @(negedge Clk);
        check("rstmid_pc_en", {31'd0, PC_En},  32'd1);
        check("rstmid_d_en",  {31'd0, D_En},   32'd1);
        check("rstmid_e_clr", {31'd0, E_Clr},  32'd1);
        check("rstmid_busy",  {31'd0, MdBusy}, 32'd1);
        tick();
        Reset = 1'b0;
        idle_inputs();
        @(negedge Clk);
        check("post_rst_busy",   {31'd0, MdBusy}, 32'd0);
        check("post_rst_err",    {31'd0, MdErr},  32'd0);
        check("post_rst_stlcnt", StallCnt,        32'd0);
        check("post_rst_e_clr",  {31'd0, E_Clr},  32'd0);
        tick();

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 4000; i++) begin
            MdStart    = ($urandom_range(0, 5) == 0);
            MdType     = $urandom_range(0, 1) == 1;
            D_UseMd    = ($urandom_range(0, 1) == 1);
            LoadUseHaz = ($urandom_range(0, 6) == 0);
            Reset      = ($urandom_range(0, 299) == 0);
            tick();
        end
        Reset = 1'b0;
        idle_inputs();
        repeat (12) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline stall and flush controller for the five-stage MIPS core. It combines the hazard unit's load-use request with an internal multiply/divide busy tracker. From these it drives the fetch-stage PC register's enable, the F/D register's enable and the D/E register's clear. It sits beside the hazard unit and owns the only timing model of the HI/LO unit that the front end consults. It also keeps a saturating-free count of stall cycles for performance reporting.

## Interface
- MULT_CYCLES, 5, busy cycles after a mult/multu issue
- DIV_CYCLES, 10, busy cycles after a div/divu issue
- Clk  in  1  clock, all state updates on posedge
- Reset  in  1  synchronous, active-high
- MdStart  in  1  E stage holds a valid mult/multu/div/divu this cycle
- MdType  in  1  0 = multiply, 1 = divide; meaningful only with MdStart
- D_UseMd  in  1  D-stage instruction reads or writes HI/LO, or is itself mult/div
- LoadUseHaz  in  1  combinational load-use stall request from the hazard unit
- PC_En  out  1  enable for the fetch PC register
- D_En  out  1  enable for the F/D pipeline register
- E_Clr  out  1  inserts a bubble into the D/E register
- MdBusy  out  1  HI/LO unit is computing
- MdErr  out  1  sticky flag: MdStart seen while MdBusy
- StallCnt  out  32  total stalled cycles since reset

## Operation
- Two states: IDLE (counter 0) and BUSY (counter > 0). The counter width is clog2(DIV_CYCLES+1).
- In IDLE, MdStart=1 at a posedge loads the counter with MULT_CYCLES or DIV_CYCLES, selected by MdType, and enters BUSY.
- In BUSY, the counter decrements each posedge. When it reaches 0 the block returns to IDLE.
- MdStart while BUSY is ignored: no reload. It sets MdErr, which holds until Reset.
- Stall = LoadUseHaz | (D_UseMd & (MdBusy | MdStart)).
- All three outputs are combinational from Stall:
  - PC_En = ~Stall
  - D_En = ~Stall
  - E_Clr = Stall
- MdBusy = (counter != 0), registered state only.
- StallCnt increments by 1 at each posedge where Stall=1 and Reset=0. It wraps from 0xFFFFFFFF to 0.
- While Reset=1, outputs are forced regardless of inputs: PC_En=1, D_En=1, E_Clr=1. This lets the PC and pipeline registers take their own reset values, and the flush is harmless.
- Reset values: counter 0, MdBusy 0, MdErr 0, StallCnt 0.

## Timing
- MdStart at edge k means MdBusy=1 during cycles k+1 through k+N, where N is MULT_CYCLES or DIV_CYCLES. MdBusy=0 from cycle k+N+1.
- A D-stage HI/LO user that arrives with MdStart in the same cycle stalls that cycle as well. Total stall is N+1 cycles.
- LoadUseHaz stalls exactly the cycles it is high. There is no added latency; the path is purely combinational.
- LoadUseHaz and the MdBusy stall together count as one stall cycle per cycle.
- Reset asserted mid-BUSY clears the counter at that edge. MdBusy=0 in the following cycle.
- Start for the next operation is accepted in the same cycle MdBusy reads 0. Back-to-back throughput is one op per N+1 cycles.

## Structure
- A shared constants header holds the MdType encodings MD_MULT=0 and MD_DIV=1. It also holds the default cycle counts so the ALU-side mult/div unit uses identical values.
- One sub-module, md_busy_cnt: parameterised load/decrement counter with MdBusy and MdErr.
- The top level holds the Stall logic, the Reset override and StallCnt.

## Test plan
- Reset, then idle inputs -> PC_En=1, D_En=1, E_Clr=0, MdBusy=0, StallCnt=0.
- MdStart=1, MdType=0 for one cycle, D_UseMd=1 held -> MdBusy high exactly 5 cycles. PC_En low for 6 cycles. StallCnt=6.
- MdStart with MdType=1, D_UseMd=0 -> MdBusy high 10 cycles, PC_En stays 1, StallCnt unchanged.
- LoadUseHaz pulsed 1 cycle during a MULT busy window with D_UseMd=1 -> a single stall per cycle, with no double count.
- Second MdStart at busy cycle 3 -> MdErr=1, busy ends at the original cycle 5, and MdErr stays 1 until Reset.
- Reset at busy cycle 4 of a divide -> MdBusy=0 the next cycle. During Reset, PC_En=1 and E_Clr=1, and StallCnt=0 after.
